// File: rtl/sweep_ctrl_pkg.sv
// Shared types for the up/down triangle sweep controller.
package sweep_ctrl_pkg;

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DONE} state_t;

  // Operation requested from the count register each cycle.
  typedef enum logic [1:0] {OP_HOLD, OP_LOAD, OP_INC, OP_DEC} cnt_op_t;

  localparam logic SEL_UP   = 1'b0;
  localparam logic SEL_DOWN = 1'b1;

endpackage

// File: rtl/sweep_count_core.sv
// Count register with load/inc/dec/hold, cleared asynchronously.
module sweep_count_core
  import sweep_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear_n,
  input  cnt_op_t          op,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      count <= '0;
    end else begin
      unique case (op)
        OP_LOAD: count <= load_val;
        OP_INC:  count <= count + WIDTH'(1);
        OP_DEC:  count <= count - WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/up_down_sweep_controller.sv
// Triangle sweep sequencer: 0..limit..0, repeated for a latched sweep total
// (or continuously when the total is 0), with start/stop and busy/done status.
module up_down_sweep_controller
  import sweep_ctrl_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SWEEP_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   clear_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [WIDTH-1:0]       limit,
  input  logic [SWEEP_CNT_W-1:0] sweeps,
  output logic                   select,
  output logic [WIDTH-1:0]       count_value,
  output logic                   busy,
  output logic                   done,
  output logic [SWEEP_CNT_W-1:0] sweep_cnt
);

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       limit_q;
  logic [SWEEP_CNT_W-1:0] sweeps_q;
  logic [SWEEP_CNT_W-1:0] sweep_cnt_q;
  logic [SWEEP_CNT_W-1:0] sweep_cnt_inc;
  logic                   sel_q, sel_d;
  logic                   accept;
  logic                   sweep_end;
  cnt_op_t                cnt_op;
  logic [WIDTH-1:0]       load_val;
  logic [WIDTH-1:0]       count;

  assign sweep_cnt_inc = sweep_cnt_q + SWEEP_CNT_W'(1);

  sweep_count_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .clear_n  (clear_n),
    .op       (cnt_op),
    .load_val (load_val),
    .count    (count)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_op    = OP_HOLD;
    load_val  = '0;
    accept    = 1'b0;
    sweep_end = 1'b0;
    if (stop) begin
      // Abort from any state; sweep_cnt keeps its value.
      state_d = S_IDLE;
      sel_d   = SEL_UP;
      cnt_op  = OP_LOAD;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            accept  = 1'b1;
            sel_d   = SEL_UP;
            cnt_op  = OP_LOAD;
            state_d = (limit == '0) ? S_DONE : S_UP;
          end
        end
        S_UP: begin
          if (count == limit_q) begin
            state_d = S_DOWN;
            sel_d   = SEL_DOWN;
            cnt_op  = OP_DEC;
          end else begin
            cnt_op  = OP_INC;
          end
        end
        S_DOWN: begin
          if (count != '0) begin
            cnt_op = OP_DEC;
          end else begin
            // Bottom of the triangle: one sweep complete.
            sweep_end = 1'b1;
            sel_d     = SEL_UP;
            cnt_op    = OP_LOAD;
            if (sweeps_q != '0 && sweep_cnt_inc == sweeps_q) begin
              state_d = S_DONE;
            end else begin
              state_d  = S_UP;
              load_val = WIDTH'(1);
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          sel_d   = SEL_UP;
          cnt_op  = OP_LOAD;
        end
        default: begin
          state_d = S_IDLE;
          sel_d   = SEL_UP;
          cnt_op  = OP_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= S_IDLE;
      sel_q       <= SEL_UP;
      limit_q     <= '0;
      sweeps_q    <= '0;
      sweep_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      if (accept) begin
        limit_q     <= limit;
        sweeps_q    <= sweeps;
        sweep_cnt_q <= '0;
      end else if (sweep_end) begin
        sweep_cnt_q <= sweep_cnt_inc;
      end
    end
  end

  assign select      = sel_q;
  assign count_value = count;
  assign busy        = (state_q == S_UP) || (state_q == S_DOWN);
  assign done        = (state_q == S_DONE);
  assign sweep_cnt   = sweep_cnt_q;

endmodule

// File: tb/tb_up_down_sweep_controller.sv
// Bench for up_down_sweep_controller: vector table, corner sequences and a
// randomized run against a positional triangle-wave model.
module tb_up_down_sweep_controller;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       start, stop;
  logic [3:0] limit;
  logic [7:0] sweeps;
  logic       sel, busy, done;
  logic [3:0] count_value;
  logic [7:0] sweep_cnt;
  logic [14:0] act;

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  up_down_sweep_controller #(.WIDTH(4), .SWEEP_CNT_W(8)) dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .start       (start),
    .stop        (stop),
    .limit       (limit),
    .sweeps      (sweeps),
    .select      (sel),
    .count_value (count_value),
    .busy        (busy),
    .done        (done),
    .sweep_cnt   (sweep_cnt)
  );

  // {sweep_cnt, count, select, busy, done}
  assign act = {sweep_cnt, count_value, sel, busy, done};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  typedef struct {
    logic        st, sp;
    logic [3:0]  lim;
    logic [7:0]  sw;
    logic [14:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic st, input logic sp, input logic [3:0] lim, input logic [7:0] sw,
                     input logic [7:0] sc, input logic [3:0] cnt, input logic s, input logic b,
                     input logic d);
    vec_t v;
    v.st = st; v.sp = sp; v.lim = lim; v.sw = sw;
    v.exp = {sc, cnt, s, b, d};
    tbl.push_back(v);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: position k since the accepting edge fully determines the outputs.
  bit m_active;
  int m_k, m_L, m_N, m_held;

  function automatic bit m_finite();
    return (m_L == 0) || (m_N != 0);
  endfunction

  function automatic int m_done_k();
    return (m_L == 0) ? 0 : 2 * m_L * m_N + 1;
  endfunction

  function automatic logic [14:0] m_exp();
    int p, c, sc;
    logic s;
    logic [31:0] t;
    if (!m_active) begin
      t = m_held;
      return {t[7:0], 7'b0};
    end
    if (m_finite() && m_k == m_done_k()) begin
      t = (m_L == 0) ? 0 : m_N;
      return {t[7:0], 4'd0, 1'b0, 1'b0, 1'b1};
    end
    if (m_k == 0) begin
      c = 0; s = 1'b0; sc = 0;
    end else begin
      p  = ((m_k - 1) % (2 * m_L)) + 1;
      c  = (p <= m_L) ? p : 2 * m_L - p;
      s  = (p > m_L);
      sc = (m_k - 1) / (2 * m_L);
    end
    t = (sc << 4) | c;
    return {t[11:0], s, 1'b1, 1'b0};
  endfunction

  task automatic m_step(input logic st, input logic sp, input logic [3:0] lim, input logic [7:0] sw);
    logic [14:0] e;
    e = m_exp();
    if (sp) begin
      if (m_active) begin
        m_held = int'(e[14:7]);
        m_active = 1'b0;
      end
    end else if (!m_active) begin
      if (st) begin
        m_active = 1'b1; m_k = 0; m_L = int'(lim); m_N = int'(sw);
      end
    end else begin
      m_k++;
      if (m_finite() && m_k > m_done_k()) begin
        m_held = (m_L == 0) ? 0 : m_N;
        m_active = 1'b0;
      end
    end
  endtask

  initial begin
    int exp3 [13] = '{0, 1, 2, 1, 0, 1, 2, 1, 0, 1, 2, 1, 0};
    int peak, prev, wrapped, done_seen;

    clear_n = 1'b0; start = 1'b0; stop = 1'b0; limit = '0; sweeps = '0;
    #1 chk("reset_state", 32'(act), 32'h0);
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
    cycle();
    chk("idle_after_reset", 32'(act), 32'h0);

    // Async reset mid-S_DOWN with count=2.
    start = 1'b1; limit = 4'd4; sweeps = 8'd1;
    cycle();
    start = 1'b0;
    repeat (6) cycle();
    chk("pre_reset_down2", 32'({count_value, sel, busy}), 32'({4'd2, 1'b1, 1'b1}));
    #2 clear_n = 1'b0;
    #1 chk("async_reset", 32'(act), 32'h0);
    @(negedge clk);
    clear_n = 1'b1;
    repeat (2) cycle();
    chk("idle_after_release", 32'(act), 32'h0);

    // Vector table.
    add(1,0,3,1, 0,0,0,1,0); add(0,0,3,1, 0,1,0,1,0); add(0,0,3,1, 0,2,0,1,0);
    add(0,0,3,1, 0,3,0,1,0); add(0,0,3,1, 0,2,1,1,0); add(0,0,3,1, 0,1,1,1,0);
    add(0,0,3,1, 0,0,1,1,0); add(0,0,3,1, 1,0,0,0,1); add(0,0,3,1, 1,0,0,0,0);
    add(1,1,5,2, 1,0,0,0,0); add(0,0,5,2, 1,0,0,0,0);
    add(1,0,0,2, 0,0,0,0,1); add(0,0,0,2, 0,0,0,0,0);
    add(1,0,2,1, 0,0,0,1,0); add(1,0,9,4, 0,1,0,1,0); add(0,0,9,4, 0,2,0,1,0);
    add(1,0,9,4, 0,1,1,1,0); add(0,0,9,4, 0,0,1,1,0); add(0,0,9,4, 1,0,0,0,1);
    add(0,0,9,4, 1,0,0,0,0);
    add(1,0,1,0, 0,0,0,1,0); add(0,0,1,0, 0,1,0,1,0); add(0,0,1,0, 0,0,1,1,0);
    add(0,0,1,0, 1,1,0,1,0); add(0,1,1,0, 1,0,0,0,0); add(0,0,1,0, 1,0,0,0,0);
    foreach (tbl[i]) begin
      start = tbl[i].st; stop = tbl[i].sp; limit = tbl[i].lim; sweeps = tbl[i].sw;
      cycle();
      chk($sformatf("vec%0d", i), 32'(act), 32'(tbl[i].exp));
    end
    start = 1'b0; stop = 1'b0;

    // Three sweeps of limit 2.
    start = 1'b1; limit = 4'd2; sweeps = 8'd3;
    for (int i = 0; i < 13; i++) begin
      cycle();
      start = 1'b0;
      chk($sformatf("tri3_k%0d", i), 32'({count_value, busy, done}), 32'({exp3[i][3:0], 1'b1, 1'b0}));
    end
    cycle();
    chk("tri3_done", 32'(act), 32'({8'd3, 4'd0, 1'b0, 1'b0, 1'b1}));
    cycle();
    chk("tri3_idle", 32'(act), 32'({8'd3, 7'd0}));

    // Continuous run at full-scale limit, then stop.
    start = 1'b1; limit = 4'd15; sweeps = 8'd0;
    peak = 0; prev = 0; wrapped = 0; done_seen = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      start = 1'b0;
      if (int'(count_value) > peak) peak = int'(count_value);
      if (int'(count_value) - prev > 1 || prev - int'(count_value) > 1) wrapped++;
      if (done) done_seen++;
      prev = int'(count_value);
    end
    chk("cont_peak", 32'(peak), 32'd15);
    chk("cont_no_wrap", 32'(wrapped), 32'd0);
    chk("cont_no_done", 32'(done_seen), 32'd0);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    chk("cont_stop", 32'({count_value, sel, busy, done}), 32'h0);

    // Randomized run against the model.
    clear_n = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    m_active = 1'b0; m_held = 0; m_k = 0; m_L = 0; m_N = 0;
    for (int i = 0; i < 2000; i++) begin
      chk($sformatf("rand%0d", i), 32'(act), 32'(m_exp()));
      start  = ($urandom_range(0, 3) == 0);
      stop   = ($urandom_range(0, 49) == 0);
      limit  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      sweeps = 8'($urandom_range(0, 3));
      m_step(start, stop, limit, sweeps);
      cycle();
    end
    chk("rand_final", 32'(act), 32'(m_exp()));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
